// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares the single-port 8K x 16 VRAM between the video scanout fetcher
// (read-only) and the CPU (read/write). Every access is sequenced through a
// small FSM. Video wins ties, but after MAX_VID_BURST consecutive video
// grants made while the CPU is waiting, the CPU is guaranteed the next slot.
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   vid_req / vid_addr      video read request (level) and word address
//   vid_ack                 one-cycle pulse, video request accepted
//   vid_rdata / vid_rvalid  registered video read data and its valid pulse
//   cpu_req / cpu_we        CPU request (level), 1 = write / 0 = read
//   cpu_addr / cpu_wdata    CPU address and write data, sampled at grant
//   cpu_ack                 one-cycle pulse, CPU request accepted
//   cpu_rdata / cpu_rvalid  registered CPU read data and its valid pulse
//   cpu_busy                combinational stall to the CPU's mem_busy
//   ram_addr / ram_wdata    registered VRAM address and write data
//   ram_we                  registered VRAM write enable
//   ram_rdata               VRAM read data, one clock after address sample
// ---------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDR_W        = 13,
    parameter int MAX_VID_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [15:0]       vid_rdata,
    output logic              vid_rvalid,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_busy,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              ram_we,
    input  logic [15:0]       ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        V_ADDR,
        V_DATA,
        C_ADDR,
        C_DATA,
        C_WR
    } state_t;

    // Streak limit as a 4-bit value so it compares directly with the counter.
    localparam logic [3:0] MAX_STREAK = 4'(MAX_VID_BURST);

    state_t            state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]       ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              vid_ack_q, vid_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [15:0]       vid_rdata_q, vid_rdata_d;
    logic              vid_rvalid_q, vid_rvalid_d;
    logic [15:0]       cpu_rdata_q, cpu_rdata_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;

    logic              vid_grant;

    // Video wins unless the CPU is waiting and video has used up its streak.
    assign vid_grant = vid_req && (!cpu_req || (streak_q < MAX_STREAK));

    // Next-state and next-output logic. Pulses (acks, rvalids, ram_we)
    // default low so each is high for exactly one cycle; address, write
    // data and read data registers default to holding their value.
    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_we_d     = 1'b0;
        vid_ack_d    = 1'b0;
        cpu_ack_d    = 1'b0;
        vid_rdata_d  = vid_rdata_q;
        vid_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_rvalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                // An idle slot with no CPU waiting ends any video streak.
                if (!cpu_req) begin
                    streak_d = 4'd0;
                end

                if (vid_grant) begin
                    state_d    = V_ADDR;
                    ram_addr_d = vid_addr;
                    vid_ack_d  = 1'b1;
                    if (cpu_req) begin
                        streak_d = (streak_q >= MAX_STREAK) ? MAX_STREAK
                                                            : streak_q + 4'd1;
                    end
                end else if (cpu_req) begin
                    ram_addr_d = cpu_addr;
                    cpu_ack_d  = 1'b1;
                    streak_d   = 4'd0;
                    if (cpu_we) begin
                        state_d     = C_WR;
                        ram_wdata_d = cpu_wdata;
                        ram_we_d    = 1'b1;
                    end else begin
                        state_d = C_ADDR;
                    end
                end
            end

            // The RAM samples ram_addr on the edge leaving *_ADDR, and its
            // data is captured on the edge leaving *_DATA.
            V_ADDR: state_d = V_DATA;

            V_DATA: begin
                state_d      = IDLE;
                vid_rdata_d  = ram_rdata;
                vid_rvalid_d = 1'b1;
            end

            C_ADDR: state_d = C_DATA;

            C_DATA: begin
                state_d      = IDLE;
                cpu_rdata_d  = ram_rdata;
                cpu_rvalid_d = 1'b1;
            end

            // ram_we falls back to its low default here, ending the write.
            C_WR: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            streak_q     <= 4'd0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= 16'd0;
            ram_we_q     <= 1'b0;
            vid_ack_q    <= 1'b0;
            cpu_ack_q    <= 1'b0;
            vid_rdata_q  <= 16'd0;
            vid_rvalid_q <= 1'b0;
            cpu_rdata_q  <= 16'd0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_we_q     <= ram_we_d;
            vid_ack_q    <= vid_ack_d;
            cpu_ack_q    <= cpu_ack_d;
            vid_rdata_q  <= vid_rdata_d;
            vid_rvalid_q <= vid_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

    // A pending video request also stalls the CPU, since video wins ties.
    assign cpu_busy   = (state_q != IDLE) || vid_req;

    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_we     = ram_we_q;
    assign vid_ack    = vid_ack_q;
    assign cpu_ack    = cpu_ack_q;
    assign vid_rdata  = vid_rdata_q;
    assign vid_rvalid = vid_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Self-checking bench for vram_arbiter. A cycle table covers a CPU write,
// a CPU read-back and a video read; hand-written sequences cover
// arbitration order, video streams, back-to-back writes and reset in the
// middle of an access. A behavioural 8K x 16 registered-read RAM sits on
// the ram_* port.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

    logic        clk;
    logic        reset;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic        vid_rvalid;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        cpu_busy;
    logic [12:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;

    logic        init_mem;
    logic [15:0] mem [0:8191];

    int total;
    int bad;

    typedef struct {
        logic        vid_req;
        logic [12:0] vid_addr;
        logic        cpu_req;
        logic        cpu_we;
        logic [12:0] cpu_addr;
        logic [15:0] cpu_wdata;
        logic        e_vid_ack;
        logic        e_cpu_ack;
        logic        e_vid_rvalid;
        logic        e_cpu_rvalid;
        logic        e_ram_we;
        logic [12:0] e_ram_addr;
        logic [15:0] e_ram_wdata;
        logic        e_cpu_busy;
        logic [15:0] e_vid_rdata;
        logic [15:0] e_cpu_rdata;
    } vec_t;

    vec_t vecs [12];

    vram_arbiter #(
        .ADDR_W        (13),
        .MAX_VID_BURST (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rdata  (vid_rdata),
        .vid_rvalid (vid_rvalid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_busy   (cpu_busy),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered-read RAM model; init_mem preloads the video test word.
    always @(posedge clk) begin
        if (init_mem) begin
            mem[13'h1FFF] <= 16'h1234;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    // Hard stop in case a sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(
        input logic vr, input logic [12:0] va,
        input logic cr, input logic cw, input logic [12:0] ca,
        input logic [15:0] cd,
        input logic eva, input logic eca, input logic evv, input logic ecv,
        input logic ewe, input logic [12:0] ea, input logic [15:0] ewd,
        input logic eb, input logic [15:0] evd, input logic [15:0] ecd);
        vec_t v;
        v.vid_req = vr;   v.vid_addr = va;
        v.cpu_req = cr;   v.cpu_we = cw;   v.cpu_addr = ca;  v.cpu_wdata = cd;
        v.e_vid_ack = eva; v.e_cpu_ack = eca;
        v.e_vid_rvalid = evv; v.e_cpu_rvalid = ecv;
        v.e_ram_we = ewe; v.e_ram_addr = ea; v.e_ram_wdata = ewd;
        v.e_cpu_busy = eb; v.e_vid_rdata = evd; v.e_cpu_rdata = ecd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        vid_req   = v.vid_req;
        vid_addr  = v.vid_addr;
        cpu_req   = v.cpu_req;
        cpu_we    = v.cpu_we;
        cpu_addr  = v.cpu_addr;
        cpu_wdata = v.cpu_wdata;
    endtask

    task automatic checkRow(input int i, input vec_t v);
        checkOutput($sformatf("row%0d vid_ack", i),    16'(vid_ack),    16'(v.e_vid_ack));
        checkOutput($sformatf("row%0d cpu_ack", i),    16'(cpu_ack),    16'(v.e_cpu_ack));
        checkOutput($sformatf("row%0d vid_rvalid", i), 16'(vid_rvalid), 16'(v.e_vid_rvalid));
        checkOutput($sformatf("row%0d cpu_rvalid", i), 16'(cpu_rvalid), 16'(v.e_cpu_rvalid));
        checkOutput($sformatf("row%0d ram_we", i),     16'(ram_we),     16'(v.e_ram_we));
        checkOutput($sformatf("row%0d ram_addr", i),   16'(ram_addr),   16'(v.e_ram_addr));
        checkOutput($sformatf("row%0d ram_wdata", i),  ram_wdata,       v.e_ram_wdata);
        checkOutput($sformatf("row%0d cpu_busy", i),   16'(cpu_busy),   16'(v.e_cpu_busy));
        checkOutput($sformatf("row%0d vid_rdata", i),  vid_rdata,       v.e_vid_rdata);
        checkOutput($sformatf("row%0d cpu_rdata", i),  cpu_rdata,       v.e_cpu_rdata);
    endtask

    task automatic idleInputs();
        vid_req   = 1'b0;
        vid_addr  = 13'h0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 13'h0;
        cpu_wdata = 16'h0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        byte   grants [10];
        string exp_order;
        int    n;
        int    cyc;
        int    ack_cyc [3];
        int    vid_count;
        logic  cpu_seen;
        int    acks;
        int    writes;
        int    we_cyc [3];
        int    rv_count;
        logic  seen;

        total = 0;
        bad   = 0;
        idleInputs();
        reset    = 1'b1;
        init_mem = 1'b1;

        // Cycle table: write 0xBEEF to 0x0010, read it back, then a video
        // read of 0x1FFF. Address changes after each grant must be ignored.
        //                  vr va       cr cw ca       cd        va ca vv cv we addr     wdata     busy vrd      crd
        vecs[0]  = mkVec(0, 13'h0000, 1, 1, 13'h0010, 16'hBEEF, 0, 0, 0, 0, 0, 13'h0000, 16'h0000, 0, 16'h0000, 16'h0000);
        vecs[1]  = mkVec(0, 13'h0000, 0, 1, 13'h0055, 16'h0000, 0, 1, 0, 0, 1, 13'h0010, 16'hBEEF, 1, 16'h0000, 16'h0000);
        vecs[2]  = mkVec(0, 13'h0000, 1, 0, 13'h0010, 16'h0000, 0, 0, 0, 0, 0, 13'h0010, 16'hBEEF, 0, 16'h0000, 16'h0000);
        vecs[3]  = mkVec(0, 13'h0000, 0, 0, 13'h0077, 16'h0000, 0, 1, 0, 0, 0, 13'h0010, 16'hBEEF, 1, 16'h0000, 16'h0000);
        vecs[4]  = mkVec(0, 13'h0000, 0, 0, 13'h0000, 16'h0000, 0, 0, 0, 0, 0, 13'h0010, 16'hBEEF, 1, 16'h0000, 16'h0000);
        vecs[5]  = mkVec(0, 13'h0000, 0, 0, 13'h0000, 16'h0000, 0, 0, 0, 1, 0, 13'h0010, 16'hBEEF, 0, 16'h0000, 16'hBEEF);
        vecs[6]  = mkVec(0, 13'h0000, 0, 0, 13'h0000, 16'h0000, 0, 0, 0, 0, 0, 13'h0010, 16'hBEEF, 0, 16'h0000, 16'hBEEF);
        vecs[7]  = mkVec(1, 13'h1FFF, 0, 0, 13'h0000, 16'h0000, 0, 0, 0, 0, 0, 13'h0010, 16'hBEEF, 1, 16'h0000, 16'hBEEF);
        vecs[8]  = mkVec(0, 13'h0000, 0, 0, 13'h0000, 16'h0000, 1, 0, 0, 0, 0, 13'h1FFF, 16'hBEEF, 1, 16'h0000, 16'hBEEF);
        vecs[9]  = mkVec(0, 13'h0000, 0, 0, 13'h0000, 16'h0000, 0, 0, 0, 0, 0, 13'h1FFF, 16'hBEEF, 1, 16'h0000, 16'hBEEF);
        vecs[10] = mkVec(0, 13'h0000, 0, 0, 13'h0000, 16'h0000, 0, 0, 1, 0, 0, 13'h1FFF, 16'hBEEF, 0, 16'h1234, 16'hBEEF);
        vecs[11] = mkVec(0, 13'h0000, 0, 0, 13'h0000, 16'h0000, 0, 0, 0, 0, 0, 13'h1FFF, 16'hBEEF, 0, 16'h1234, 16'hBEEF);

        repeat (3) @(posedge clk);
        #1;
        init_mem = 1'b0;
        reset    = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkRow(i, vecs[i]);
            @(posedge clk);
            #1;
        end
        idleInputs();
        repeat (3) stepCycle();

        // Both requesters held: video gets four grants, then the CPU.
        $display("[TB] arbitration order with both requests held");
        exp_order = "VVVVCVVVVC";
        n = 0;
        vid_req  = 1'b1;
        vid_addr = 13'h0100;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0010;
        for (int c = 0; c < 60 && n < 10; c++) begin
            stepCycle();
            if (vid_ack && n < 10) begin
                grants[n] = "V";
                n++;
            end
            if (cpu_ack && n < 10) begin
                grants[n] = "C";
                n++;
            end
        end
        checkOutput("arb grant count", 16'(n), 16'd10);
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("arb grant%0d", k), 16'(grants[k]), 16'(exp_order[k]));
        end
        idleInputs();
        repeat (6) stepCycle();

        // Video alone streams one grant every 3 cycles; a CPU request raised
        // mid-stream then waits for exactly four more video grants.
        $display("[TB] video stream and late CPU request");
        n   = 0;
        cyc = 0;
        vid_req  = 1'b1;
        vid_addr = 13'h0200;
        for (int c = 0; c < 30 && n < 3; c++) begin
            stepCycle();
            cyc++;
            if (vid_ack) begin
                ack_cyc[n] = cyc;
                n++;
            end
        end
        checkOutput("stream ack count", 16'(n), 16'd3);
        if (n == 3) begin
            checkOutput("stream spacing0", 16'(ack_cyc[1] - ack_cyc[0]), 16'd3);
            checkOutput("stream spacing1", 16'(ack_cyc[2] - ack_cyc[1]), 16'd3);
        end
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0010;
        vid_count = 0;
        cpu_seen  = 1'b0;
        for (int c = 0; c < 40 && !cpu_seen; c++) begin
            stepCycle();
            if (vid_ack) vid_count++;
            if (cpu_ack) cpu_seen = 1'b1;
        end
        checkOutput("late cpu granted", 16'(cpu_seen), 16'd1);
        checkOutput("late cpu video grants before", 16'(vid_count), 16'd4);
        idleInputs();
        repeat (6) stepCycle();

        // Back-to-back CPU writes with cpu_req held across three acks.
        $display("[TB] back-to-back CPU writes");
        acks   = 0;
        writes = 0;
        cyc    = 0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 13'h0000;
        cpu_wdata = 16'hA000;
        for (int c = 0; c < 20 && writes < 3; c++) begin
            stepCycle();
            cyc++;
            if (ram_we) begin
                checkOutput($sformatf("b2b addr%0d", writes), 16'(ram_addr), 16'(writes));
                checkOutput($sformatf("b2b data%0d", writes), ram_wdata, 16'hA000 + 16'(writes));
                we_cyc[writes] = cyc;
                writes++;
            end
            if (cpu_ack) begin
                acks++;
                if (acks >= 3) begin
                    cpu_req = 1'b0;
                end else begin
                    cpu_addr  = 13'(acks);
                    cpu_wdata = 16'hA000 + 16'(acks);
                end
            end
        end
        checkOutput("b2b write count", 16'(writes), 16'd3);
        if (writes == 3) begin
            checkOutput("b2b spacing0", 16'(we_cyc[1] - we_cyc[0]), 16'd2);
            checkOutput("b2b spacing1", 16'(we_cyc[2] - we_cyc[1]), 16'd2);
        end
        idleInputs();
        repeat (3) stepCycle();
        checkOutput("b2b ram word0", mem[0], 16'hA000);
        checkOutput("b2b ram word1", mem[1], 16'hA001);
        checkOutput("b2b ram word2", mem[2], 16'hA002);

        // Reset while a write is on the RAM port drops ram_we at once.
        $display("[TB] reset during write and during read");
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 13'h0033;
        cpu_wdata = 16'h5555;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            stepCycle();
            if (ram_we) seen = 1'b1;
        end
        checkOutput("rst write started", 16'(seen), 16'd1);
        cpu_req = 1'b0;
        reset   = 1'b1;
        #1;
        checkOutput("rst ram_we", 16'(ram_we), 16'd0);
        checkOutput("rst cpu_ack", 16'(cpu_ack), 16'd0);
        checkOutput("rst cpu_busy", 16'(cpu_busy), 16'd0);
        checkOutput("rst ram_addr", 16'(ram_addr), 16'd0);
        checkOutput("rst cpu_rdata", cpu_rdata, 16'h0000);
        stepCycle();
        reset = 1'b0;
        stepCycle();

        // Reset during a read must not be followed by a cpu_rvalid.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0010;
        stepCycle();
        checkOutput("rst read ack", 16'(cpu_ack), 16'd1);
        cpu_req = 1'b0;
        reset   = 1'b1;
        #1;
        checkOutput("rst read busy", 16'(cpu_busy), 16'd0);
        stepCycle();
        reset = 1'b0;
        rv_count = 0;
        for (int c = 0; c < 6; c++) begin
            stepCycle();
            if (cpu_rvalid) rv_count++;
        end
        checkOutput("rst read no rvalid", 16'(rv_count), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 8K x 16 VRAM (CPU window 0x4000-0x5FFF) between two requesters: the video scanout fetcher (read-only) and the CPU (read/write).
- Sequences every VRAM access through a small FSM and applies bounded-priority arbitration: video wins ties, but the CPU is guaranteed a slot after MAX_VID_BURST consecutive video grants.
- Its cpu_busy output drives the CPU's mem_busy input.

Parameters:
- ADDR_W, 13: VRAM word-address width.
- MAX_VID_BURST, 4: maximum consecutive video grants while cpu_req is pending. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- vid_req  in  1  video read request (level).
- vid_addr  in  ADDR_W  video read address.
- vid_ack  out  1  one-cycle pulse: video request accepted.
- vid_rdata  out  16  video read data, registered.
- vid_rvalid  out  1  one-cycle pulse: vid_rdata is valid.
- cpu_req  in  1  CPU access request (level).
- cpu_we  in  1  1 = write, 0 = read; sampled at grant.
- cpu_addr  in  ADDR_W  CPU address; sampled at grant.
- cpu_wdata  in  16  CPU write data; sampled at grant.
- cpu_ack  out  1  one-cycle pulse: CPU request accepted.
- cpu_rdata  out  16  CPU read data, registered.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata is valid (reads only).
- cpu_busy  out  1  combinational: (state != IDLE) || vid_req.
- ram_addr  out  ADDR_W  VRAM address, registered.
- ram_wdata  out  16  VRAM write data, registered.
- ram_we  out  1  VRAM write enable, registered.
- ram_rdata  in  16  VRAM read data; valid one clock after the address is sampled (registered BRAM read).

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - ram_we, vid_ack, cpu_ack, vid_rvalid and cpu_rvalid go to 0.
  - ram_addr, ram_wdata, vid_rdata and cpu_rdata go to 0.
  - The streak counter clears.
  - Any in-flight access is abandoned; no rvalid is issued for it after reset.
- FSM states: IDLE, V_ADDR, V_DATA, C_ADDR, C_DATA, C_WR.
- Grant decision, made only in IDLE:
  - Video is granted if vid_req && (!cpu_req || streak < MAX_VID_BURST).
  - Otherwise the CPU is granted if cpu_req.
  - With no request, the FSM stays in IDLE.
- On the grant edge:
  - The granted address is loaded into ram_addr.
  - The corresponding ack is set to 1 for exactly the next cycle.
  - The requester must drop its req, or present a new request, by the following edge. A request still held is treated as new, which allows back-to-back accesses.
- Video read: IDLE -> V_ADDR -> V_DATA -> IDLE.
  - The V_DATA exit edge captures ram_rdata into vid_rdata and pulses vid_rvalid.
  - vid_rvalid is high in the 3rd cycle after the IDLE cycle in which the grant was decided.
- CPU read: IDLE -> C_ADDR -> C_DATA -> IDLE, with the same timing, using cpu_rdata and cpu_rvalid.
- CPU write: IDLE -> C_WR -> IDLE.
  - The grant edge sets ram_wdata = cpu_wdata and ram_we = 1.
  - The C_WR exit edge clears ram_we.
  - ram_we is high for exactly one cycle. No cpu_rvalid is issued.
- Streak counter (4 bits):
  - +1 on each video grant made while cpu_req = 1.
  - Cleared on every CPU grant.
  - Cleared on any IDLE cycle with cpu_req = 0.
  - Saturates at MAX_VID_BURST.
- Throughput: one access per 3 cycles for reads and one per 2 cycles for writes. There are no dead cycles beyond IDLE.
- ram_addr and ram_wdata hold their values outside active accesses; ram_we = 0 outside C_WR.
- vid_addr and cpu_addr changes after grant have no effect on the access in flight.
- Address wrap: addresses are ADDR_W bits; no range checking is done (the CPU's address decode is external).

Test Plan:
- Reset mid-access: assert reset during C_WR with ram_we = 1 -> ram_we = 0 immediately (before the next edge); state IDLE; no cpu_rvalid afterwards.
- Single CPU write, then read: cpu_req = 1, cpu_we = 1, cpu_addr = 0x0010, cpu_wdata = 0xBEEF -> cpu_ack 1 cycle; ram_we high exactly 1 cycle with ram_addr = 0x0010, ram_wdata = 0xBEEF. Then a read of 0x0010 -> cpu_rvalid 3 cycles after grant decision, cpu_rdata = 0xBEEF.
- Video read latency: vid_req, vid_addr = 0x1FFF (RAM model preloaded with 0x1234) -> vid_ack in cycle 1, vid_rvalid in cycle 3, vid_rdata = 0x1234; cpu_busy = 1 throughout.
- Simultaneous requests, MAX_VID_BURST = 4: both held continuously -> grant order V,V,V,V,C,V,V,V,V,C; the CPU is never starved beyond 4 video grants.
- Contention without CPU: vid_req held, cpu_req = 0 -> continuous video grants every 3 cycles; streak stays 0. Raising cpu_req mid-stream -> CPU granted after at most 4 further video grants.
- Back-to-back CPU writes: cpu_req held across 3 acks with addresses 0x0000, 0x0001, 0x0002 -> ram_we pulses every 2 cycles; each write lands with its own address and data.
